// File: rtl/sprite_pkg.sv
// Shared sprite constants: RGBA4444 texel layout, screen geometry and the alpha shade helper.
package sprite_pkg;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;

  localparam int RGBA_R_LSB = 12;
  localparam int RGBA_G_LSB = 8;
  localparam int RGBA_B_LSB = 4;
  localparam int RGBA_A_LSB = 0;

  typedef struct packed {
    logic signed [16:0] pos;
    logic signed [16:0] vel;
  } axis_t;

  // Channel index 0/1/2 -> R/G/B bit offset inside a texel.
  function automatic int chan_lsb(input int ch);
    case (ch)
      0:       return RGBA_R_LSB;
      1:       return RGBA_G_LSB;
      default: return RGBA_B_LSB;
    endcase
  endfunction

  function automatic logic [3:0] shade(input logic [3:0] c, input logic [3:0] a);
    logic [7:0] prod;
    prod = {4'b0, c} * {4'b0, a};
    return prod[7:4];
  endfunction

endpackage

// File: rtl/sprite_if.sv
// Raster-in / ROM / shaded-pixel-out bundle between the video pipeline and the sprite stage.
interface sprite_if #(
  parameter int ADDR_W = 13
);
  logic              pix_valid;
  logic [15:0]       pix_x;
  logic [15:0]       pix_y;
  logic              frame_tick;
  logic              move_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              out_valid;
  logic              out_draw;
  logic [3:0]        out_red;
  logic [3:0]        out_green;
  logic [3:0]        out_blue;
  logic [15:0]       sprite_x;
  logic [15:0]       sprite_y;

  modport master (
    output pix_valid, pix_x, pix_y, frame_tick, move_en, rom_data,
    input  rom_addr, out_valid, out_draw, out_red, out_green, out_blue,
           sprite_x, sprite_y
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_tick, move_en, rom_data,
    output rom_addr, out_valid, out_draw, out_red, out_green, out_blue,
           sprite_x, sprite_y
  );
endinterface

// File: rtl/sprite_motion.sv
// Frame-rate sprite state: bouncing position/velocity per axis and the animation frame counter.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int IMG_W       = 50,
  parameter int IMG_H       = 67,
  parameter int SCALE_SHIFT = 1,
  parameter int SCREEN_W    = SCREEN_W_PX,
  parameter int SCREEN_H    = SCREEN_H_PX,
  parameter int VEL_X       = 2,
  parameter int VEL_Y       = 2,
  parameter int ANIM_SHIFT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        move_en,
  output logic [15:0] sprite_x,
  output logic [15:0] sprite_y,
  output logic        frame_sel
);

  localparam logic signed [16:0] SPAN_X = 17'(IMG_W << SCALE_SHIFT);
  localparam logic signed [16:0] SPAN_Y = 17'(IMG_H << SCALE_SHIFT);
  localparam logic signed [16:0] LIM_X  = 17'(SCREEN_W);
  localparam logic signed [16:0] LIM_Y  = 17'(SCREEN_H);
  localparam axis_t RST_X = '{pos: 17'sd0, vel: 17'(VEL_X)};
  localparam axis_t RST_Y = '{pos: 17'sd0, vel: 17'(VEL_Y)};

  axis_t      ax_x_q, ax_x_d;
  axis_t      ax_y_q, ax_y_d;
  logic [7:0] cnt_q, cnt_d;

  // Landing exactly on the far wall is allowed; only overshoot clamps and reflects.
  function automatic axis_t axis_step(input axis_t cur, input logic signed [16:0] span,
                                      input logic signed [16:0] lim);
    axis_t              nxt;
    logic signed [16:0] np;
    nxt = cur;
    np  = cur.pos + cur.vel;
    if (np < 17'sd0) begin
      nxt.pos = 17'sd0;
      nxt.vel = -cur.vel;
    end else if (np + span > lim) begin
      nxt.pos = lim - span;
      nxt.vel = -cur.vel;
    end else begin
      nxt.pos = np;
    end
    return nxt;
  endfunction

  always_comb begin
    ax_x_d = ax_x_q;
    ax_y_d = ax_y_q;
    cnt_d  = cnt_q;
    if (frame_tick) begin
      cnt_d = cnt_q + 8'd1;
      if (move_en) begin
        ax_x_d = axis_step(ax_x_q, SPAN_X, LIM_X);
        ax_y_d = axis_step(ax_y_q, SPAN_Y, LIM_Y);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ax_x_q <= RST_X;
      ax_y_q <= RST_Y;
      cnt_q  <= '0;
    end else begin
      ax_x_q <= ax_x_d;
      ax_y_q <= ax_y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sprite_x  = ax_x_q.pos[15:0];
  assign sprite_y  = ax_y_q.pos[15:0];
  assign frame_sel = cnt_q[ANIM_SHIFT];

endmodule

// File: rtl/sprite_engine.sv
// Per-pixel sprite stage: maps raster coordinates into a scaled sprite ROM window
// and shades opaque texels by alpha over a fixed 3-cycle, stall-free pipeline.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int IMG_W       = 50,
  parameter int IMG_H       = 67,
  parameter int SCALE_SHIFT = 1,
  parameter int SCREEN_W    = SCREEN_W_PX,
  parameter int SCREEN_H    = SCREEN_H_PX,
  parameter int VEL_X       = 2,
  parameter int VEL_Y       = 2,
  parameter int ANIM_SHIFT  = 4,
  parameter int ADDR_W      = 13
) (
  input logic     clk,
  input logic     rst,
  sprite_if.slave bus
);

  localparam logic [16:0]       SW          = 17'(IMG_W << SCALE_SHIFT);
  localparam logic [16:0]       SH          = 17'(IMG_H << SCALE_SHIFT);
  localparam logic [ADDR_W-1:0] IMG_W_A     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(IMG_W * IMG_H);

  logic [15:0]       sprite_x, sprite_y;
  logic              frame_sel;
  logic [16:0]       px, py, sx, sy;
  logic [15:0]       rel_x, rel_y;
  logic [ADDR_W-1:0] col, row;
  logic              in_box;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              v0_q, box0_q, v1_q, box1_q;
  logic              out_valid_q, out_draw_q;
  logic [15:0]       texel;
  logic [3:0]        alpha;
  logic              draw_d;
  logic [2:0][3:0]   chan_d, chan_q;

  sprite_motion #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .SCALE_SHIFT(SCALE_SHIFT),
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .VEL_X      (VEL_X),
    .VEL_Y      (VEL_Y),
    .ANIM_SHIFT (ANIM_SHIFT)
  ) u_motion (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(bus.frame_tick),
    .move_en   (bus.move_en),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .frame_sel (frame_sel)
  );

  // C0: box test and texel address; the address register parks outside the box.
  always_comb begin
    px     = {1'b0, bus.pix_x};
    py     = {1'b0, bus.pix_y};
    sx     = {1'b0, sprite_x};
    sy     = {1'b0, sprite_y};
    in_box = bus.pix_valid && (px >= sx) && (px < sx + SW) && (py >= sy) && (py < sy + SH);
    rel_x  = bus.pix_x - sprite_x;
    rel_y  = bus.pix_y - sprite_y;
    col    = ADDR_W'(rel_x >> SCALE_SHIFT);
    row    = ADDR_W'(rel_y >> SCALE_SHIFT);
    rom_addr_d = rom_addr_q;
    if (in_box) begin
      rom_addr_d = (frame_sel ? FRAME_WORDS : '0) + row * IMG_W_A + col;
    end
  end

  // C2: an all-zero texel is the transparency key; any other texel draws, even at A=0.
  assign texel  = bus.rom_data;
  assign alpha  = texel[RGBA_A_LSB +: 4];
  assign draw_d = box1_q && (texel != '0);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    localparam int LSB = chan_lsb(gi);
    assign chan_d[gi] = draw_d ? shade(texel[LSB +: 4], alpha) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr_q  <= '0;
      v0_q        <= 1'b0;
      box0_q      <= 1'b0;
      v1_q        <= 1'b0;
      box1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_draw_q  <= 1'b0;
      chan_q      <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      v0_q        <= bus.pix_valid;
      box0_q      <= in_box;
      v1_q        <= v0_q;
      box1_q      <= box0_q;
      out_valid_q <= v1_q;
      out_draw_q  <= draw_d;
      chan_q      <= chan_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_draw  = out_draw_q;
  assign bus.out_red   = chan_q[0];
  assign bus.out_green = chan_q[1];
  assign bus.out_blue  = chan_q[2];
  assign bus.sprite_x  = sprite_x;
  assign bus.sprite_y  = sprite_y;

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: random raster/tick stimulus against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_sprite_engine;
  import sprite_pkg::*;

  localparam int IMG_W = 50;
  localparam int IMG_H = 67;
  localparam int SW    = 100;
  localparam int SH    = 134;
  localparam int FW    = IMG_W * IMG_H;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int cnt;
  } mstate_t;

  typedef struct {
    int cyc;
    int draw;
    int r;
    int g;
    int b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sprite_if #(.ADDR_W(13)) bus ();
  sprite_if #(.ADDR_W(13)) bus2 ();

  sprite_engine u_dut (.clk(clk), .rst(rst), .bus(bus));
  sprite_engine #(.VEL_X(-7), .VEL_Y(-7)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [15:0] rom [0:8191];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int      vectors = 0;
  int      miscompares = 0;
  int      cyc = 0;
  exp_t    sb[$];
  mstate_t m1, m2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mstate_t mstep(input mstate_t s, input bit mv);
    mstate_t r;
    int nx, ny;
    r = s;
    r.cnt = (s.cnt + 1) % 256;
    if (mv) begin
      nx = s.x + s.vx;
      ny = s.y + s.vy;
      if (nx < 0) begin r.x = 0; r.vx = -s.vx; end
      else if (nx + SW > 640) begin r.x = 640 - SW; r.vx = -s.vx; end
      else r.x = nx;
      if (ny < 0) begin r.y = 0; r.vy = -s.vy; end
      else if (ny + SH > 480) begin r.y = 480 - SH; r.vy = -s.vy; end
      else r.y = ny;
    end
    return r;
  endfunction

  function automatic exp_t expect_pix(input mstate_t s, input int px, input int py, input int c);
    exp_t e;
    int t, a, addr;
    e.cyc = c; e.draw = 0; e.r = 0; e.g = 0; e.b = 0;
    if (px >= s.x && px < s.x + SW && py >= s.y && py < s.y + SH) begin
      addr = ((s.cnt / 16) % 2) * FW + ((py - s.y) / 2) * IMG_W + (px - s.x) / 2;
      t = int'(rom[addr]);
      if (t != 0) begin
        a = t % 16;
        e.draw = 1;
        e.r = ((t / 4096) % 16) * a / 16;
        e.g = ((t / 256) % 16) * a / 16;
        e.b = ((t / 16) % 16) * a / 16;
      end
    end
    return e;
  endfunction

  function automatic mstate_t mreset(input int vx, input int vy);
    mstate_t s;
    s.x = 0; s.y = 0; s.vx = vx; s.vy = vy; s.cnt = 0;
    return s;
  endfunction

  task automatic check_pos();
    check("dut1_x", int'(bus.sprite_x), m1.x);
    check("dut1_y", int'(bus.sprite_y), m1.y);
    check("dut2_x", int'(bus2.sprite_x), m2.x);
    check("dut2_y", int'(bus2.sprite_y), m2.y);
  endtask

  // One raster cycle: queue the expected pixel, advance the model, step the clock.
  task automatic drive(input bit v, input int x, input int y, input bit tick, input bit mv);
    bus.pix_valid   = v;
    bus.pix_x       = 16'(x);
    bus.pix_y       = 16'(y);
    bus.frame_tick  = tick;
    bus.move_en     = mv;
    bus2.frame_tick = tick;
    bus2.move_en    = mv;
    if (v) sb.push_back(expect_pix(m1, x, y, cyc + 3));
    if (tick) begin
      m1 = mstep(m1, mv);
      m2 = mstep(m2, mv);
    end
    @(posedge clk); #1;
    bus.pix_valid   = 1'b0;
    bus.frame_tick  = 1'b0;
    bus2.frame_tick = 1'b0;
    check_pos();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.cyc);
          check("draw", int'(bus.out_draw), e.draw);
          check("red", int'(bus.out_red), e.r);
          check("green", int'(bus.out_green), e.g);
          check("blue", int'(bus.out_blue), e.b);
        end
      end else begin
        check("idle_out", int'({bus.out_draw, bus.out_red, bus.out_green, bus.out_blue}), 0);
      end
    end
  end

  initial begin
    int lo, hi, ylo, yhi;
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
    bus.frame_tick = 1'b0; bus.move_en = 1'b0;
    bus2.pix_valid = 1'b0; bus2.pix_x = '0; bus2.pix_y = '0;
    bus2.frame_tick = 1'b0; bus2.move_en = 1'b0; bus2.rom_data = '0;
    for (int i = 0; i < 8192; i++) begin
      case ($urandom_range(0, 7))
        0:       rom[i] = 16'h0000;
        1:       rom[i] = {16'($urandom_range(0, 4095)) << 4};
        default: rom[i] = 16'($urandom_range(0, 65535));
      endcase
    end
    rom[0] = 16'hF00F;
    rom[1] = 16'h0000;
    rom[2] = 16'h8880;
    m1 = mreset(2, 2);
    m2 = mreset(-7, -7);

    #12;
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    check("rst_out", int'({bus.out_valid, bus.out_draw, bus.out_red, bus.out_green, bus.out_blue}), 0);
    check_pos();
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed mapping, edges and transparency at sprite (0,0), frame 0.
    drive(1'b1, 0, 0, 1'b0, 1'b0);     check("addr_0_0", int'(bus.rom_addr), 0);
    drive(1'b1, 100, 0, 1'b0, 1'b0);   check("addr_hold_right", int'(bus.rom_addr), 0);
    drive(1'b1, 3, 5, 1'b0, 1'b0);     check("addr_3_5", int'(bus.rom_addr), 101);
    drive(1'b1, 99, 133, 1'b0, 1'b0);  check("addr_99_133", int'(bus.rom_addr), 3349);
    drive(1'b1, 100, 133, 1'b0, 1'b0); check("addr_hold_100_133", int'(bus.rom_addr), 3349);
    drive(1'b1, 2, 0, 1'b0, 1'b0);     check("addr_transp", int'(bus.rom_addr), 1);
    drive(1'b1, 4, 0, 1'b0, 1'b0);     check("addr_alpha0", int'(bus.rom_addr), 2);
    idle(4);

    // Sixteen frames without motion select the second animation frame.
    for (int i = 0; i < 16; i++) drive(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0);     check("addr_anim", int'(bus.rom_addr), 3350);
    idle(4);

    // Randomized raster around the sprite with frequent frame ticks (bounces on all walls).
    for (int i = 0; i < 1500; i++) begin
      lo  = (m1.x > 6) ? m1.x - 6 : 0;
      hi  = (m1.x + SW + 6 > 639) ? 639 : m1.x + SW + 6;
      ylo = (m1.y > 6) ? m1.y - 6 : 0;
      yhi = (m1.y + SH + 6 > 479) ? 479 : m1.y + SH + 6;
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(hi, lo)), int'($urandom_range(yhi, ylo)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);
    end

    // Reset in the middle of a busy stream.
    for (int i = 0; i < 3; i++) drive(1'b1, m1.x + 2 * i, m1.y + 1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    m1 = mreset(2, 2);
    m2 = mreset(-7, -7);
    check("midrst_out", int'({bus.out_valid, bus.out_draw, bus.out_red, bus.out_green, bus.out_blue}), 0);
    check("midrst_rom_addr", int'(bus.rom_addr), 0);
    check_pos();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 2 * i, i, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
